muldiv_unit: RTL
================

# muldiv_unit

Iterative, parametrised integer multiply/divide unit for the EX stage. It replaces the single-cycle `*` product path with a W-cycle shift-add multiplier and a restoring divider behind a valid/ready handshake. It reports `busy_o` so EX can hold its over signal, and it supports pipeline flush. The destination tag travels with each operation so EX can drive its dest/forwarding outputs when the result returns.

## Interface
Parameters:
- `W`, 32, operand/result width; must be ≥ 4 and a power of two.
- `TAG_W`, 5, width of the pass-through tag (destination register address).

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_n_i`  in  1  reset, asynchronous and active-low.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit can accept a request; high only in IDLE.
- `op_i`  in  3  0 MUL (low W), 1 MULH (signed×signed, high W), 2 MULHU (unsigned, high W), 3 DIV (signed), 4 MOD (signed), 5 DIVU, 6 MODU, 7 treated as MUL.
- `opd1_i`  in  W  multiplicand / dividend.
- `opd2_i`  in  W  multiplier / divisor.
- `tag_i`  in  TAG_W  tag captured with the request.
- `flush_i`  in  1  abort any in-flight or completed-but-unconsumed operation.
- `valid_o`  out  1  `result_o`/`tag_o` valid.
- `ready_i`  in  1  consumer accepts the result.
- `result_o`  out  W  result.
- `tag_o`  out  TAG_W  tag of the returned result.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept when `valid_i & ready_o & ~flush_i` is true in IDLE. Capture op, tag, operand signs and operand magnitudes. Magnitudes use the absolute value for signed ops (DIV, MOD, MULH) and the raw value otherwise.
- IDLE→CALC on accept. Exception: a divide op with `opd2_i == 0` goes IDLE→DONE directly with the result already formed.
- CALC: a counter of width clog2(W)+1 runs 0..W-1. Each cycle performs one step:
  - Multiply: shift-add step into a 2W accumulator.
  - Divide: restoring step (shift remainder left, trial subtract, set quotient bit).
- CALC→FIX after W steps.
- FIX: sign correction and result select, then →DONE.
  - Signed product is negated when operand signs differ.
  - Quotient is negated when signs differ.
  - Remainder takes the dividend's sign.
  - MUL/MULH/MULHU select the low or high W bits of the 2W product.
- DONE: `valid_o` = 1. `result_o` and `tag_o` are held stable until `valid_o & ready_i`, then →IDLE.
- Division by zero: quotient = all ones (signed and unsigned); remainder = dividend unchanged.
- Signed overflow (MIN / −1): quotient = MIN, remainder = 0. The magnitude algorithm produces this naturally; no special case.
- Flush: `flush_i` high in any state → IDLE on the next edge.
  - `valid_o` drops and the result is discarded.
  - A request presented together with `flush_i` in IDLE is not accepted.
  - Flush takes priority over `ready_i` in DONE.

## Timing
- Reset values: state IDLE, `ready_o` 1, `valid_o` 0, `busy_o` 0, `result_o` 0, `tag_o` 0, counter 0.
- Request accepted at the end of cycle 0:
  - CALC during cycles 1..W, FIX in cycle W+1.
  - `valid_o` first high in cycle W+2. With W=32 this is 34 cycles from request to first `valid_o`.
- Divide-by-zero: `valid_o` high in cycle 1.
- No back-to-back issue. After the result handshake in cycle N, `ready_o` is high in cycle N+1; the earliest next accept is the end of cycle N+1.
- `ready_o` and `busy_o` are pure decodes of registered state; there is no combinational path from any input.
- `result_o` and `tag_o` are registered and change only when entering DONE.
- Asserting reset in any state forces the reset values immediately, with no pending `valid_o`.

## Test plan
- MUL 7 × 0xFFFFFFFD (W=32) → `result_o` 0xFFFFFFEB, `valid_o` first in cycle 34, tag 5'd9 returned.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide, dividend 0xFFFFFFF9 (−7), divisor 2:
  - DIV → 0xFFFFFFFD; MOD → 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; MOD of the same → 0.
- DIVU 5/0 → 0xFFFFFFFF and MODU 5/0 → 5, each with `valid_o` in cycle 1.
- Flush in cycle 10 of a DIV → IDLE next cycle; `valid_o` never asserts; `ready_o` high in cycle 11; a following MUL 3 × 4 returns 12.
- Backpressure:
  - `ready_i` held low 5 cycles in DONE → `result_o`/`tag_o` stable throughout, `ready_o` stays low.
  - Reset pulsed mid-CALC → all outputs at reset values.
  - Repeat the MUL/DIV vectors with W=8: e.g. DIV 0xF9 / 0x02 → 0xFD, `valid_o` in cycle 10.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: W-step shift-add multiplier and restoring divider
// behind a valid/ready handshake, with flush and a pass-through destination tag.
module muldiv_unit #(
  parameter int W     = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [W-1:0]     opd1_i,
  input  logic [W-1:0]     opd2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [W-1:0]     result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);
  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MOD   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MODU  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic               r_is_mul;
  logic               r_sign1;
  logic               r_sign2;
  logic [W-1:0]       r_addend;
  logic [2*W-1:0]     r_acc;
  logic [CW-1:0]      r_cnt;
  logic [W-1:0]       r_result;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W-1:0]   r_tag_out;

  logic               w_is_mul;
  logic               w_is_signed;
  logic [W-1:0]       w_mag1;
  logic [W-1:0]       w_mag2;
  logic [W:0]         w_mul_sum;
  logic [W:0]         w_shift;
  logic [W:0]         w_trial;
  logic [2*W-1:0]     w_mul_next;
  logic [2*W-1:0]     w_div_next;
  logic [2*W-1:0]     w_prod;
  logic [W-1:0]       w_quot;
  logic [W-1:0]       w_rem;
  logic [W-1:0]       w_fix_result;

  assign w_is_mul    = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHU) || (op_i == 3'd7);
  assign w_is_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_MOD);
  assign w_mag1      = (w_is_signed && opd1_i[W-1]) ? -opd1_i : opd1_i;
  assign w_mag2      = (w_is_signed && opd2_i[W-1]) ? -opd2_i : opd2_i;

  // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_addend} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Divide: acc = {remainder, dividend bits becoming quotient bits}.
  assign w_shift    = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_trial    = w_shift - {1'b0, r_addend};
  assign w_div_next = w_trial[W] ? {w_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                 : {w_trial[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_prod = ((r_op == OP_MULH) && (r_sign1 ^ r_sign2)) ? -r_acc : r_acc;
  assign w_quot = r_acc[W-1:0];
  assign w_rem  = r_acc[2*W-1:W];

  always_comb begin
    w_fix_result = w_prod[W-1:0];
    case (r_op)
      OP_MULH, OP_MULHU: w_fix_result = w_prod[2*W-1:W];
      OP_DIV:            w_fix_result = (r_sign1 ^ r_sign2) ? -w_quot : w_quot;
      OP_MOD:            w_fix_result = r_sign1 ? -w_rem : w_rem;
      OP_DIVU:           w_fix_result = w_quot;
      OP_MODU:           w_fix_result = w_rem;
      default:           w_fix_result = w_prod[W-1:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MUL;
      r_is_mul  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_addend  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_tag     <= '0;
      r_tag_out <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_op     <= op_i;
            r_is_mul <= w_is_mul;
            r_sign1  <= w_is_signed & opd1_i[W-1];
            r_sign2  <= w_is_signed & opd2_i[W-1];
            r_tag    <= tag_i;
            r_cnt    <= '0;
            r_addend <= w_is_mul ? w_mag1 : w_mag2;
            r_acc    <= {{W{1'b0}}, (w_is_mul ? w_mag2 : w_mag1)};
            // Divide by zero skips the datapath: quotient all ones, remainder = dividend.
            if (!w_is_mul && (opd2_i == '0)) begin
              r_result  <= ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? '1 : opd1_i;
              r_tag_out <= tag_i;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_is_mul ? w_mul_next : w_div_next;
          if (r_cnt == CW'(W - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          r_result  <= w_fix_result;
          r_tag_out <= r_tag;
          r_state   <= S_DONE;
        end
        default: begin
          if (ready_i) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = (r_state != S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;
  assign tag_o    = r_tag_out;
endmodule
